// File: rtl/ctx_arb.sv
// -----------------------------------------------------------------------------
// ctx_arb
//   Round-robin arbiter and sequencer that shares one CTX datapath
//   (val/in[7:0] -> out[7:0], fixed latency CTX_LAT) among NUM_REQ requesters.
//   One request is accepted per cycle and launched into the CTX input
//   registers. The id of each launch is carried through an owner pipeline
//   matched to the CTX latency, so every result goes back to the requester
//   that issued it. Results return in issue order, one per cycle at most.
//
//   Arbitration: the last granted requester keeps the grant while it keeps
//   requesting, up to MAX_BURST consecutive grants. After that it yields, but
//   only to a requester that is actually waiting. Otherwise the grant goes to
//   the first requester found by scanning upward from rr_ptr.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req_val   in   [NUM_REQ]    per-requester request valid
//   req_data  in   [8*NUM_REQ]  per-requester operand, requester i at [8i+7:8i]
//   req_rdy   out  [NUM_REQ]    one-hot accept, combinational
//   ctx_val   out  CTX input valid, registered
//   ctx_in    out  [8]  CTX operand, registered
//   ctx_out   in   [8]  CTX result
//   rsp_val   out  [NUM_REQ]    one-hot response valid, registered
//   rsp_data  out  [8]  response data, qualified by rsp_val
//   gnt_id    out  [3]  id of the last accepted requester (debug), registered
// -----------------------------------------------------------------------------
module ctx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int CTX_LAT   = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_val,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic                 ctx_val,
    output logic [7:0]           ctx_in,
    input  logic [7:0]           ctx_out,
    output logic [NUM_REQ-1:0]   rsp_val,
    output logic [7:0]           rsp_data,
    output logic [2:0]           gnt_id
);

    localparam int IDW = 3;
    localparam int BCW = 4;
    localparam logic [IDW:0]   NUM_REQ_W   = (IDW+1)'(NUM_REQ);
    localparam logic [BCW-1:0] MAX_BURST_W = BCW'(MAX_BURST);

    // Arbiter state
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_last_id;
    logic [BCW-1:0] r_burst_cnt;

    // CTX launch registers
    logic           r_ctx_val;
    logic [7:0]     r_ctx_in;

    // Owner pipeline; index CTX_LAT-1 is the head, aligned with ctx_out
    logic [CTX_LAT-1:0]          r_own_val;
    logic [CTX_LAT-1:0][IDW-1:0] r_own_id;

    // Response registers
    logic [NUM_REQ-1:0] r_rsp_val;
    logic [7:0]         r_rsp_data;

    // Arbitration wires
    logic [NUM_REQ-1:0] w_last_oh;
    logic               w_last_req;
    logic               w_others_wait;
    logic               w_sticky;
    logic [NUM_REQ-1:0] w_rot;
    logic               w_rr_found;
    logic [IDW-1:0]     w_rr_id;
    logic               w_gnt_any;
    logic [IDW-1:0]     w_gnt_id;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [7:0]         w_gnt_data;
    logic [IDW-1:0]     w_next_ptr;

    // Reduce a sum of an id and an offset below 2*NUM_REQ back into range.
    function automatic logic [IDW-1:0] wrap_id(input logic [IDW:0] s);
        return (s >= NUM_REQ_W) ? IDW'(s - NUM_REQ_W) : IDW'(s);
    endfunction

    assign w_last_oh     = NUM_REQ'(1) << r_last_id;
    assign w_last_req    = |(req_val & w_last_oh);
    assign w_others_wait = |(req_val & ~w_last_oh);

    // Burst limit only bites when someone else is waiting; a lone requester
    // streams without bubbles.
    assign w_sticky = w_last_req && ((r_burst_cnt < MAX_BURST_W) || !w_others_wait);

    // Rotate so that bit 0 corresponds to rr_ptr; the lowest set bit of the
    // rotated vector is then the round-robin winner.
    assign w_rot = NUM_REQ'({req_val, req_val} >> r_rr_ptr);

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // up front, so no path leaves it unassigned and no latch is inferred.
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        // Descending scan: the last hit written is the lowest rotated index.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rr_found = 1'b1;
                w_rr_id    = wrap_id({1'b0, r_rr_ptr} + (IDW+1)'(k));
            end
        end
    end

    assign w_gnt_any  = w_sticky || w_rr_found;
    assign w_gnt_id   = w_sticky ? r_last_id : w_rr_id;
    assign w_gnt_oh   = w_gnt_any ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign w_next_ptr = wrap_id({1'b0, w_gnt_id} + (IDW+1)'(1));

    // Operand select as an AND-OR over the one-hot grant.
    always_comb begin
        w_gnt_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_oh[k]) begin
                w_gnt_data = w_gnt_data | req_data[8*k +: 8];
            end
        end
    end

    // Arbiter state update on every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_last_id   <= '0;
            r_burst_cnt <= '0;
        end else if (w_gnt_any) begin
            // NOTE: sequential state is always written with non-blocking
            // assignments so every register samples pre-edge values.
            if (w_gnt_id == r_last_id) begin
                if (r_burst_cnt != MAX_BURST_W) begin
                    r_burst_cnt <= r_burst_cnt + BCW'(1);
                end
            end else begin
                r_burst_cnt <= BCW'(1);
            end
            r_last_id <= w_gnt_id;
            r_rr_ptr  <= w_next_ptr;
        end
    end

    // CTX launch: ctx_in holds its value between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctx_val <= 1'b0;
            r_ctx_in  <= '0;
        end else begin
            r_ctx_val <= w_gnt_any;
            if (w_gnt_any) begin
                r_ctx_in <= w_gnt_data;
            end
        end
    end

    // Owner pipeline and response retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only the valid bits matter for correctness, but the ids are
            // small and resetting them keeps the pipeline free of X.
            r_own_val  <= '0;
            r_own_id   <= '0;
            r_rsp_val  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_own_val[0] <= r_ctx_val;
            r_own_id[0]  <= r_last_id;
            for (int k = 1; k < CTX_LAT; k++) begin
                r_own_val[k] <= r_own_val[k-1];
                r_own_id[k]  <= r_own_id[k-1];
            end
            r_rsp_val <= r_own_val[CTX_LAT-1] ? (NUM_REQ'(1) << r_own_id[CTX_LAT-1]) : '0;
            if (r_own_val[CTX_LAT-1]) begin
                r_rsp_data <= ctx_out;
            end
        end
    end

    assign req_rdy  = w_gnt_oh;
    assign ctx_val  = r_ctx_val;
    assign ctx_in   = r_ctx_in;
    assign rsp_val  = r_rsp_val;
    assign rsp_data = r_rsp_data;
    assign gnt_id   = r_last_id;

endmodule

// File: tb/tb_ctx_arb.sv
// -----------------------------------------------------------------------------
// tb_ctx_arb
//   Directed bench for ctx_arb (NUM_REQ=4, CTX_LAT=2, MAX_BURST=4).
//   Each stimulus cycle carries a hand-written expected req_rdy. From that
//   grant the bench posts the expected ctx launch one cycle later and the
//   response CTX_LAT+2 cycles later. The CTX block is modelled as bitwise
//   invert with CTX_LAT cycles of delay. Every output is compared every cycle
//   on the falling edge, including the hold behaviour of ctx_in, gnt_id and
//   rsp_data.
// -----------------------------------------------------------------------------
module tb_ctx_arb;

    localparam int NUM_REQ   = 4;
    localparam int CTX_LAT   = 2;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 512;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_REQ-1:0]   req_val = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_rdy;
    logic                 ctx_val;
    logic [7:0]           ctx_in;
    logic [7:0]           ctx_out;
    logic [NUM_REQ-1:0]   rsp_val;
    logic [7:0]           rsp_data;
    logic [2:0]           gnt_id;

    ctx_arb #(
        .NUM_REQ  (NUM_REQ),
        .CTX_LAT  (CTX_LAT),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_val (req_val),
        .req_data(req_data),
        .req_rdy (req_rdy),
        .ctx_val (ctx_val),
        .ctx_in  (ctx_in),
        .ctx_out (ctx_out),
        .rsp_val (rsp_val),
        .rsp_data(rsp_data),
        .gnt_id  (gnt_id)
    );

    always #5 clk = ~clk;

    // Cycle counter, advances on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CTX model: result = ~operand, CTX_LAT cycles after ctx_val.
    logic [7:0] ctx_pipe [CTX_LAT];
    always @(posedge clk) begin
        ctx_pipe[0] <= ctx_val ? ~ctx_in : 8'hEE;
        for (int k = 1; k < CTX_LAT; k++) ctx_pipe[k] <= ctx_pipe[k-1];
    end
    assign ctx_out = ctx_pipe[CTX_LAT-1];

    // Expected values indexed by cycle.
    logic       exp_rdy [DEPTH];
    logic [3:0] exp_rdy_v [DEPTH];
    logic       exp_cv  [DEPTH];
    logic [7:0] exp_ci  [DEPTH];
    logic [2:0] exp_gid [DEPTH];
    logic [3:0] exp_rv  [DEPTH];
    logic [7:0] exp_rd  [DEPTH];
    logic       exp_rst [DEPTH];

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;
    int   dcnt [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Operand of requester g for its c-th transfer; requester 2's first
    // operand is 0x5A.
    function automatic logic [7:0] dval(input int g, input int c);
        logic [7:0] x;
        x = {g[3:0], c[3:0]};
        return x ^ 8'h7A;
    endfunction

    // All comparisons happen here, away from the rising edge.
    logic [7:0] held_ci  = '0;
    logic [2:0] held_gid = '0;
    logic [7:0] held_rd  = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_rst[cyc]) begin
                held_ci  = '0;
                held_gid = '0;
                held_rd  = '0;
            end
            if (exp_cv[cyc]) begin
                held_ci  = exp_ci[cyc];
                held_gid = exp_gid[cyc];
            end
            if (exp_rv[cyc] != 4'b0) held_rd = exp_rd[cyc];
            check("req_rdy",  32'(req_rdy),  32'(exp_rdy_v[cyc]));
            check("ctx_val",  32'(ctx_val),  32'(exp_cv[cyc]));
            check("ctx_in",   32'(ctx_in),   32'(held_ci));
            check("gnt_id",   32'(gnt_id),   32'(held_gid));
            check("rsp_val",  32'(rsp_val),  32'(exp_rv[cyc]));
            check("rsp_data", 32'(rsp_data), 32'(held_rd));
        end
    end

    // Protocol monitor: a pending request must stay valid with stable data.
    logic [NUM_REQ-1:0]   pend = '0;
    logic [8*NUM_REQ-1:0] pdata = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i]) begin
                    assert (req_val[i] && (req_data[8*i +: 8] == pdata[8*i +: 8]))
                    else $error("protocol violation on requester %0d", i);
                end
            end
            pend  <= req_val & ~req_rdy;
            pdata <= req_data;
        end
    end

    // One stimulus cycle: drive req_val, post the expected grant and what
    // follows from it.
    task automatic step(input logic [3:0] v, input logic [3:0] er);
        int   g;
        logic [7:0] d;
        @(posedge clk);
        #1;
        req_val = v;
        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = dval(i, dcnt[i]);
        exp_rdy_v[cyc] = er;
        if (er != 4'b0) begin
            g = 0;
            for (int i = 0; i < NUM_REQ; i++) if (er[i]) g = i;
            d = dval(g, dcnt[g]);
            exp_cv[cyc+1]               = 1'b1;
            exp_ci[cyc+1]               = d;
            exp_gid[cyc+1]              = 3'(g);
            exp_rv[cyc+2+CTX_LAT]       = er;
            exp_rd[cyc+2+CTX_LAT]       = ~d;
            dcnt[g]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000);
    endtask

    // Reset for one cycle, dropping every expectation still in flight.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        req_val = '0;
        for (int i = cyc; i < DEPTH; i++) begin
            exp_rdy_v[i] = '0;
            exp_cv[i]    = 1'b0;
            exp_rv[i]    = '0;
        end
        exp_rst[cyc] = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_rdy[i] = 1'b0; exp_rdy_v[i] = '0; exp_cv[i] = 1'b0; exp_ci[i] = '0;
            exp_gid[i] = '0; exp_rv[i] = '0; exp_rd[i] = '0; exp_rst[i] = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) dcnt[i] = 0;

        // Power-on reset; reset values are checked on the falling edges.
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single request: req 2, 0x5A -> response 0xA5 four cycles later.
        step(4'b0100, 4'b0100);
        idle(6);

        // All four at once after reset: 0,1,2,3 in order.
        do_reset();
        step(4'b1111, 4'b0001);
        step(4'b1110, 4'b0010);
        step(4'b1100, 4'b0100);
        step(4'b1000, 4'b1000);
        idle(6);

        // Burst limit: req 0 streams, req 1 joins at cycle 1.
        do_reset();
        step(4'b0001, 4'b0001);
        step(4'b0011, 4'b0001);
        step(4'b0011, 4'b0001);
        step(4'b0011, 4'b0001);
        step(4'b0011, 4'b0010);
        step(4'b0001, 4'b0001);
        idle(6);

        // Lone streamer: ten back-to-back grants to req 3, then wrap-around
        // with req 3 at its burst limit: req 0 first, then req 3.
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b1000, 4'b1000);
        step(4'b1001, 4'b0001);
        step(4'b1000, 4'b1000);
        idle(6);

        // Reset mid-flight: transfers at cycles 0 and 1, reset in cycle 2.
        do_reset();
        step(4'b0010, 4'b0010);
        step(4'b0100, 4'b0100);
        do_reset();
        idle(8);
        // rr_ptr is back at 0, so req 1 beats req 3.
        step(4'b1010, 4'b0010);
        step(4'b1000, 4'b1000);
        idle(6);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
